// File: rtl/alu_bist_pkg.sv
// Shared types and the constant vector table for the ALU built-in self-test.
// Expected results follow the RV32I ALU: zero = (d == 0), lt = signed(op1) < signed(op2).
package alu_bist_pkg;

    typedef enum logic [3:0] {
        ALU_NOP0 = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_SLL  = 4'h3,
        ALU_SRL  = 4'h4,
        ALU_SRA  = 4'h5,
        ALU_AND  = 4'h6,
        ALU_OR   = 4'h7,
        ALU_XOR  = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_SLTU = 4'ha,
        ALU_PASS = 4'hb,
        ALU_NOPC = 4'hc,
        ALU_NOPD = 4'hd,
        ALU_NOPE = 4'he,
        ALU_NOPF = 4'hf
    } alu_func_t;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_func_t   func;
        logic [31:0] exp_d;
        logic        exp_zero;
        logic        exp_lt;
    } alu_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } bist_state_e;

    localparam int ALU_BIST_NUM_VEC = 16;

    // Every (op1, op2, func) triple is unique so a failing vector is unambiguous.
    localparam alu_vec_t ALU_VEC_TABLE [ALU_BIST_NUM_VEC] = '{
        '{32'h0000_0005, 32'h0000_0003, ALU_NOP0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h1234_5678, 32'hfedc_ba98, ALU_ADD,  32'h1111_1110, 1'b0, 1'b0},
        '{32'h0000_0010, 32'h0000_0020, ALU_SUB,  32'hffff_fff0, 1'b0, 1'b1},
        '{32'h1234_5678, 32'h0000_0010, ALU_SLL,  32'h5678_0000, 1'b0, 1'b0},
        '{32'h8000_0000, 32'h0000_0004, ALU_SRL,  32'h0800_0000, 1'b0, 1'b1},
        '{32'h8000_0000, 32'h0000_0004, ALU_SRA,  32'hf800_0000, 1'b0, 1'b1},
        '{32'hf0f0_f0f0, 32'h0f0f_0f0f, ALU_AND,  32'h0000_0000, 1'b1, 1'b1},
        '{32'hf0f0_f0f0, 32'h0f0f_0f0f, ALU_OR,   32'hffff_ffff, 1'b0, 1'b1},
        '{32'haaaa_aaaa, 32'haaaa_aaaa, ALU_XOR,  32'h0000_0000, 1'b1, 1'b0},
        '{32'hffff_ffff, 32'h0000_0001, ALU_SLT,  32'h0000_0001, 1'b0, 1'b1},
        '{32'hffff_ffff, 32'h0000_0001, ALU_SLTU, 32'h0000_0000, 1'b1, 1'b1},
        '{32'hdead_beef, 32'h0000_0000, ALU_PASS, 32'hdead_beef, 1'b0, 1'b1},
        '{32'h7fff_ffff, 32'h8000_0000, ALU_NOPC, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h7fff_ffff, 32'h0000_0001, ALU_ADD,  32'h8000_0000, 1'b0, 1'b0},
        '{32'h0000_0001, 32'h0000_003f, ALU_SLL,  32'h8000_0000, 1'b0, 1'b1},
        '{32'h7fff_ffff, 32'h0000_001f, ALU_SRA,  32'h0000_0000, 1'b1, 1'b0}
    };

endpackage

// File: rtl/alu_bist_rom.sv
// Combinational lookup of one self-test vector by index.
module alu_bist_rom
    import alu_bist_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output alu_vec_t         vec_o
);

    // NOTE: a constant table is pure decode; it holds no state and needs no reset.
    always_comb begin
        vec_o = ALU_VEC_TABLE[idx_i];
    end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test initiator: steps through the vector table, drives the ALU operands,
// compares the ALU response and reports a verdict, error count and first failing index.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int NUM_VEC       = ALU_BIST_NUM_VEC,
    parameter int SETTLE_CYCLES = 1,
    parameter int IDX_W         = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [31:0]      op1_o,
    output logic [31:0]      op2_o,
    output logic [3:0]       func_o,
    input  logic [31:0]      d_i,
    input  logic             zero_i,
    input  logic             lt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [IDX_W:0]   err_cnt_o,
    output logic             first_err_vld_o,
    output logic [IDX_W-1:0] first_err_idx_o
);

    localparam int               WAIT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VEC - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W:0]    ERR_MAX   = '1;
    localparam logic [IDX_W:0]    ERR_ONE   = (IDX_W+1)'(1);

    bist_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       op1_q, op1_d;
    logic [31:0]       op2_q, op2_d;
    logic [3:0]        func_q, func_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [IDX_W:0]    err_cnt_q, err_cnt_d;
    logic              first_vld_q, first_vld_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d;

    alu_vec_t vec;
    logic     mismatch;

    alu_bist_rom #(.IDX_W(IDX_W)) u_rom (
        .idx_i (idx_q),
        .vec_o (vec)
    );

    assign mismatch = (d_i != vec.exp_d) | (zero_i != vec.exp_zero) | (lt_i != vec.exp_lt);

    // NOTE: every _d gets its hold value first, so no branch can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        func_d      = func_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_vld_d = first_vld_q;
        first_idx_d = first_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_cnt_d   = '0;
                    first_vld_d = 1'b0;
                    first_idx_d = '0;
                    pass_d      = 1'b0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                op1_d   = vec.op1;
                op2_d   = vec.op2;
                func_d  = vec.func;
                wait_d  = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (wait_q == WAIT_LAST) state_d = ST_CHECK;
                else                     wait_d  = wait_q + WAIT_ONE;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
                    if (!first_vld_q) begin
                        first_vld_d = 1'b1;
                        first_idx_d = idx_q;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    // Outputs are registered, so DONE's values are loaded on the way in.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt_d == '0);
                    op1_d   = '0;
                    op2_d   = '0;
                    func_d  = '0;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides any update above, including a CHECK in the same cycle.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_cnt_d   = err_cnt_q;
            first_vld_d = first_vld_q;
            first_idx_d = first_idx_q;
            op1_d       = '0;
            op2_d       = '0;
            func_d      = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            func_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            func_q      <= func_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign op1_o           = op1_q;
    assign op2_o           = op2_q;
    assign func_o          = func_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_vld_o = first_vld_q;
    assign first_err_idx_o = first_idx_q;

endmodule
